// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the reset sequencer: FSM states, reset-cause codes, counter sizing.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    STRETCH = 2'd1,
    RELEASE = 2'd2,
    DONE    = 2'd3
  } seq_state_t;

  localparam logic [1:0] CAUSE_ASYNC = 2'b01;
  localparam logic [1:0] CAUSE_SW    = 2'b10;

  // Bits needed to hold the larger of the two programmable intervals.
  function automatic int cnt_width(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/rst_sync_chain.sv
// Active-high reset synchroniser: asserts asynchronously, deasserts on the SYNC_STAGES-th clock
// edge after async_rst falls.
module rst_sync_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic async_rst,
  output logic sync_rst
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b0};
    end
  end

  assign sync_rst = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Synchronises async_rst, stretches it, then releases NUM_CHANNELS reset domains in order with a fixed gap.
// Optional RST_SEQ_CAUSE_EN adds rst_cause reporting whether the last sequence came from async or software reset.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int NUM_CHANNELS   = 4,
  parameter int STRETCH_CYCLES = 8,
  parameter int RELEASE_GAP    = 4
) (
  input  logic                    clk,
  input  logic                    async_rst,
  input  logic                    sw_rst_req,
  output logic [NUM_CHANNELS-1:0] rst_out,
  output logic                    rst_done
`ifdef RST_SEQ_CAUSE_EN
  ,
  output logic [1:0]              rst_cause
`endif
);

  localparam int CW = cnt_width(STRETCH_CYCLES, RELEASE_GAP);
  localparam int IW = $clog2(NUM_CHANNELS + 1);
  localparam logic [CW-1:0] STRETCH_LD = CW'(STRETCH_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD     = CW'(RELEASE_GAP - 1);
  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_CHANNELS - 1);

  logic w_sync_rst;
  logic w_hold;

  seq_state_t              r_state;
  logic [CW-1:0]           r_cnt;
  logic [IW-1:0]           r_idx;
  logic [NUM_CHANNELS-1:0] r_rst_out;
  logic                    r_rst_done;

  rst_sync_chain #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .async_rst(async_rst),
    .sync_rst (w_sync_rst)
  );

  assign w_hold = w_sync_rst | sw_rst_req;

  // Counters are preloaded with interval-1 so a release lands exactly interval edges after the reload.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      r_state    <= HOLD;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_rst_out  <= '1;
      r_rst_done <= 1'b0;
    end else if (w_hold) begin
      r_state    <= HOLD;
      r_cnt      <= STRETCH_LD;
      r_idx      <= '0;
      r_rst_out  <= '1;
      r_rst_done <= 1'b0;
    end else begin
      case (r_state)
        HOLD, STRETCH: begin
          if (r_cnt == '0) begin
            r_rst_out[0] <= 1'b0;
            if (NUM_CHANNELS == 1) begin
              r_state    <= DONE;
              r_rst_done <= 1'b1;
            end else begin
              r_state <= RELEASE;
              r_idx   <= IW'(1);
              r_cnt   <= GAP_LD;
            end
          end else begin
            r_state <= STRETCH;
            r_cnt   <= r_cnt - CW'(1);
          end
        end
        RELEASE: begin
          if (r_cnt == '0) begin
            r_rst_out <= r_rst_out & ~(NUM_CHANNELS'(1) << r_idx);
            if (r_idx == LAST_IDX) begin
              r_state    <= DONE;
              r_rst_done <= 1'b1;
            end else begin
              r_idx <= r_idx + IW'(1);
              r_cnt <= GAP_LD;
            end
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        DONE: begin
          r_state <= DONE;
        end
        default: begin
          r_state <= HOLD;
        end
      endcase
    end
  end

  assign rst_out  = r_rst_out;
  assign rst_done = r_rst_done;

`ifdef RST_SEQ_CAUSE_EN
  logic [1:0] r_cause;

  // Software cause only when the synchroniser is already quiet, so async resets keep priority.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      r_cause <= CAUSE_ASYNC;
    end else if (sw_rst_req && !w_sync_rst) begin
      r_cause <= CAUSE_SW;
    end
  end

  assign rst_cause = r_cause;
`endif

endmodule
